// File: rtl/excess3_deserializer.sv
// excess3_deserializer
// Serial-to-parallel collector for the Excess-3 bit stream produced by the
// serial BCD-to-Excess-3 converter. Bits arrive LSB first, four per digit,
// one per clock. Framing is implied by the shared reset: the first rising
// edge after reset release samples bit 0 of digit 0.
//
// Optional feature macro: E3_CHECK_EN
//   defined   : illegal-code detection drives code_err_o / word_err_o
//   undefined : range check and error accumulator are not built, both
//               error outputs are tied low
module excess3_deserializer #(
    parameter int DIGITS = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_i,      // active-low, asynchronous
    input  logic                  x_i,
    output logic [3:0]            digit_o,
    output logic                  digit_valid_o,
    output logic [3:0]            bcd_digit_o,
    output logic                  code_err_o,
    output logic [4*DIGITS-1:0]   word_o,
    output logic [4*DIGITS-1:0]   bcd_word_o,
    output logic                  word_valid_o,
    output logic                  word_err_o
);

    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int WW = 4 * DIGITS;

    logic [1:0]    bit_cnt_q;
    logic [DW-1:0] dig_cnt_q;
    // Only the three older bits are kept; the fourth is the live input.
    logic [2:0]    sr_q;
    logic [WW-1:0] word_acc_q;

    logic [3:0]    digit_q;
    logic [3:0]    bcd_digit_q;
    logic          digit_valid_q;
    logic [WW-1:0] word_q;
    logic [WW-1:0] bcd_word_q;
    logic          word_valid_q;

    logic [3:0]    nib_d;
    logic [WW-1:0] word_d;
    logic [WW-1:0] bcd_word_d;
    logic          bit_last;
    logic          dig_last;

    assign nib_d    = {x_i, sr_q};
    assign bit_last = (bit_cnt_q == 2'd3);
    assign dig_last = (dig_cnt_q == DW'(DIGITS - 1));

    // Word accumulator with the current nibble merged in, plus its per-nibble BCD
    always_comb begin
        word_d     = word_acc_q;
        bcd_word_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_cnt_q == DW'(i)) begin
                word_d[4*i +: 4] = nib_d;
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            bcd_word_d[4*i +: 4] = word_d[4*i +: 4] - 4'd3;
        end
    end

    // Framing counters, shift register and registered digit/word outputs
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            bit_cnt_q     <= '0;
            dig_cnt_q     <= '0;
            sr_q          <= '0;
            word_acc_q    <= '0;
            digit_q       <= '0;
            bcd_digit_q   <= '0;
            digit_valid_q <= 1'b0;
            word_q        <= '0;
            bcd_word_q    <= '0;
            word_valid_q  <= 1'b0;
        end else begin
            bit_cnt_q     <= bit_cnt_q + 2'd1;
            sr_q          <= nib_d[3:1];
            digit_valid_q <= 1'b0;
            word_valid_q  <= 1'b0;
            if (bit_last) begin
                digit_q       <= nib_d;
                bcd_digit_q   <= nib_d - 4'd3;
                digit_valid_q <= 1'b1;
                word_acc_q    <= word_d;
                if (dig_last) begin
                    dig_cnt_q    <= '0;
                    word_q       <= word_d;
                    bcd_word_q   <= bcd_word_d;
                    word_valid_q <= 1'b1;
                end else begin
                    dig_cnt_q <= dig_cnt_q + DW'(1);
                end
            end
        end
    end

`ifdef E3_CHECK_EN
    logic code_err_d;
    logic code_err_q;
    logic err_acc_q;
    logic word_err_q;

    // Legal Excess-3 digits are 0011..1100
    assign code_err_d = (nib_d < 4'd3) || (nib_d > 4'd12);

    // Per-digit error flag and per-word sticky accumulator
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            code_err_q <= 1'b0;
            err_acc_q  <= 1'b0;
            word_err_q <= 1'b0;
        end else if (bit_last) begin
            code_err_q <= code_err_d;
            if (dig_last) begin
                word_err_q <= err_acc_q | code_err_d;
                err_acc_q  <= 1'b0;
            end else begin
                err_acc_q <= err_acc_q | code_err_d;
            end
        end
    end

    assign code_err_o = code_err_q;
    assign word_err_o = word_err_q;
`else
    assign code_err_o = 1'b0;
    assign word_err_o = 1'b0;
`endif

    assign digit_o       = digit_q;
    assign bcd_digit_o   = bcd_digit_q;
    assign digit_valid_o = digit_valid_q;
    assign word_o        = word_q;
    assign bcd_word_o    = bcd_word_q;
    assign word_valid_o  = word_valid_q;

endmodule

// File: tb/tb_excess3_deserializer.sv
// Testbench for excess3_deserializer (DIGITS=4). Stimulus pushes expected
// digit/word results into queues; a negedge monitor pops and compares on
// every digit_valid / word_valid pulse.
module tb_excess3_deserializer;

    localparam int DIGITS = 4;
    localparam int WW     = 4 * DIGITS;

    logic          clk;
    logic          rst_n;
    logic          x;
    logic [3:0]    digit;
    logic          digit_valid;
    logic [3:0]    bcd_digit;
    logic          code_err;
    logic [WW-1:0] word;
    logic [WW-1:0] bcd_word;
    logic          word_valid;
    logic          word_err;

    int checks = 0;
    int errors = 0;

    logic [8:0]        exp_dig_q[$];   // {digit, bcd_digit, code_err}
    logic [2*WW:0]     exp_word_q[$];  // {word, bcd_word, word_err}

    logic [WW-1:0] acc_word;
    logic          acc_err;
    int            didx;

    excess3_deserializer #(.DIGITS(DIGITS)) dut (
        .clock_i       (clk),
        .reset_i       (rst_n),
        .x_i           (x),
        .digit_o       (digit),
        .digit_valid_o (digit_valid),
        .bcd_digit_o   (bcd_digit),
        .code_err_o    (code_err),
        .word_o        (word),
        .bcd_word_o    (bcd_word),
        .word_valid_o  (word_valid),
        .word_err_o    (word_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_err(input logic [3:0] n);
`ifdef E3_CHECK_EN
        return (n < 4'd3) || (n > 4'd12);
`else
        return 1'b0;
`endif
    endfunction

    // Mealy model of the upstream converter: serial add of 0011, LSB first
    function automatic logic [3:0] conv_bits(input logic [3:0] bcd);
        logic [3:0] three;
        logic [3:0] z;
        logic       c;
        three = 4'b0011;
        c = 1'b0;
        for (int k = 0; k < 4; k++) begin
            z[k] = bcd[k] ^ three[k] ^ c;
            c    = (bcd[k] & three[k]) | (bcd[k] & c) | (three[k] & c);
        end
        return z;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic send_digit(input logic [3:0] nib);
        logic e;
        logic [WW-1:0] bw;
        e = exp_err(nib);
        exp_dig_q.push_back({nib, 4'(nib - 4'd3), e});
        acc_word[4*didx +: 4] = nib;
        acc_err = acc_err | e;
        if (didx == DIGITS - 1) begin
            for (int i = 0; i < DIGITS; i++) bw[4*i +: 4] = acc_word[4*i +: 4] - 4'd3;
            exp_word_q.push_back({acc_word, bw, acc_err});
            acc_err = 1'b0;
            didx = 0;
        end else begin
            didx++;
        end
        for (int k = 0; k < 4; k++) begin
            x = nib[k];
            @(negedge clk);
        end
    endtask

    // Asserts reset now, checks outputs are cleared, releases on a negedge
    task automatic do_reset();
        rst_n = 1'b0;
        x = 1'b0;
        acc_word = '0;
        acc_err = 1'b0;
        didx = 0;
        #1;
        check("reset_async_clear", {digit, bcd_digit, code_err, digit_valid,
               word, bcd_word, word_err, word_valid}, 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("reset_hold_clear", {digit, bcd_digit, code_err, digit_valid,
                   word, bcd_word, word_err, word_valid}, 64'd0);
        end
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (digit_valid) begin
                if (exp_dig_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL digit_unexpected actual=%h required=no_pulse", digit);
                end else begin
                    check("digit", 64'({digit, bcd_digit, code_err}), 64'(exp_dig_q.pop_front()));
                end
            end
            if (word_valid) begin
                if (exp_word_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word_unexpected actual=%h required=no_pulse", word);
                end else begin
                    check("word", 64'({word, bcd_word, word_err}), 64'(exp_word_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        x = 1'b0;
        acc_word = '0;
        acc_err = 1'b0;
        didx = 0;
        @(negedge clk);
        do_reset();

        // Word 7654 / BCD 4321; word_valid lands 16 edges after release
        send_digit(4'h4);
        send_digit(4'h5);
        send_digit(4'h6);
        send_digit(4'h7);
        check("word_valid_latency", 64'({word_valid, word}), 64'({1'b1, 16'h7654}));
        check("bcd_word_direct", 64'(bcd_word), 64'h4321);

        // Illegal 1111 plus boundary codes
        send_digit(4'hF);
        check("digit_1111", 64'({digit_valid, digit, bcd_digit}), 64'({1'b1, 4'hF, 4'hC}));
        send_digit(4'h3);
        send_digit(4'hC);
        send_digit(4'h2);
        check("word_err_end", 64'(word_err), 64'(exp_err(4'hF)));

        // More boundary/illegal codes, including modulo-16 wrap of 0001
        send_digit(4'hD);
        send_digit(4'h1);
        send_digit(4'h9);
        send_digit(4'h8);
        check("bcd_of_0001", 64'(bcd_word[7:4]), 64'hE);

        // Reset after two bits of digit 2
        send_digit(4'h6);
        send_digit(4'hA);
        x = 1'b1; @(negedge clk);
        x = 1'b0; @(negedge clk);
        #2;
        do_reset();

        // Post-reset word: 1000 (BCD 5) then converter outputs of 9, 0, 7
        send_digit(4'b1000);
        check("digit_bcd5", 64'({digit_valid, digit, bcd_digit, code_err}),
              64'({1'b1, 4'b1000, 4'd5, 1'b0}));
        send_digit(conv_bits(4'd9));
        check("e2e_bcd9", 64'({digit, bcd_digit}), 64'({4'b1100, 4'd9}));
        send_digit(conv_bits(4'd0));
        send_digit(conv_bits(4'd7));
        check("post_reset_word", 64'(word), 64'hA3C8);

        x = 1'b0;
        repeat (2) @(negedge clk);
        check("digit_queue_drained", 64'(exp_dig_q.size()), 64'd0);
        check("word_queue_drained", 64'(exp_word_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
